// File: rtl/alu_share_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_share_arb_pkg
// Shared definitions for the ALU-sharing arbiter:
//   - default operand width and requester count
//   - funct codes understood by the shared ALU
//   - arbiter FSM state encoding
//   - helper that tells whether a funct code is executable
// -----------------------------------------------------------------------------
package alu_share_arb_pkg;

    localparam int DW_DEF   = 32;
    localparam int NREQ_DEF = 2;
    localparam int FW       = 6;

    localparam logic [FW-1:0] F_AND = 6'b100100;
    localparam logic [FW-1:0] F_OR  = 6'b100101;
    localparam logic [FW-1:0] F_ADD = 6'b100000;
    localparam logic [FW-1:0] F_SUB = 6'b100010;
    localparam logic [FW-1:0] F_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Only these codes are forwarded to the ALU; anything else is answered
    // directly by the arbiter with an error response.
    function automatic logic funct_supported(input logic [FW-1:0] f);
        logic ok;
        ok = 1'b0;
        case (f)
            F_AND, F_OR, F_ADD, F_SUB, F_SLT: ok = 1'b1;
            default:                          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_share_arb_rr_arb2.sv
// -----------------------------------------------------------------------------
// alu_share_arb_rr_arb2
// Two-way round-robin grant generator (rr_arb2) with its own pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector (2 bits)
//   advance    : a grant was consumed this cycle; move the pointer
//   gnt        : one-hot grant (zero when nothing requests)
//   gnt_idx    : index of the granted requester
// The requester at the pointer index wins ties; after every consumed grant
// the pointer moves to the other index, so simultaneous requests alternate.
// -----------------------------------------------------------------------------
module alu_share_arb_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    logic ptr_reg;

    always_comb begin
        gnt_idx = ptr_reg;
        gnt     = 2'b00;
        if (!req[ptr_reg]) begin
            gnt_idx = ~ptr_reg;
        end
        if (req[gnt_idx]) begin
            gnt = 2'b01 << gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= 1'b0;
        end else if (advance) begin
            ptr_reg <= ~gnt_idx;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// -----------------------------------------------------------------------------
// alu_share_arb
// Shares one external combinational ALU between two requesters.
// One operation is in flight at a time: IDLE accepts a request, EXEC drives
// the ALU for one cycle and captures its result, RESP holds the response
// until the granted requester accepts it.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_valid/req_ready     : per-requester request handshake (ready one-hot)
//   req_a, req_b            : packed 32-bit operands, requester i at [32i+:32]
//   req_funct               : packed 6-bit funct, requester i at [6i+:6]
//   alu_dataA/B, alu_signal : operands and funct to the shared ALU
//   alu_reset               : active-high output clear to the ALU
//   alu_dataOut             : ALU result (combinational from alu_*)
//   rsp_valid/rsp_ready     : per-requester response handshake (valid one-hot)
//   rsp_data, rsp_err       : result and unsupported-funct flag
// -----------------------------------------------------------------------------
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int NREQ = NREQ_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    input  logic [NREQ*FW-1:0] req_funct,
    output logic [DW-1:0]      alu_dataA,
    output logic [DW-1:0]      alu_dataB,
    output logic [FW-1:0]      alu_signal,
    output logic               alu_reset,
    input  logic [DW-1:0]      alu_dataOut,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic               rsp_err,
    input  logic [NREQ-1:0]    rsp_ready
);

    // Unpacked per-requester views of the packed request buses
    logic [DW-1:0] a_arr     [NREQ];
    logic [DW-1:0] b_arr     [NREQ];
    logic [FW-1:0] funct_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign a_arr[gi]     = req_a[gi*DW +: DW];
        assign b_arr[gi]     = req_b[gi*DW +: DW];
        assign funct_arr[gi] = req_funct[gi*FW +: FW];
    end

    state_t        state_reg, state_next;
    logic [DW-1:0] a_reg;
    logic [DW-1:0] b_reg;
    logic [FW-1:0] funct_reg;
    logic          grant_reg;
    logic [DW-1:0] result_reg;
    logic          err_reg;

    logic [1:0]    arb_gnt;
    logic          arb_idx;
    logic          accept;
    logic          sel_supported;

    alu_share_arb_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (accept),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign sel_supported = funct_supported(funct_arr[arb_idx]);

    // Next-state and output decode
    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        rsp_valid  = '0;
        alu_dataA  = '0;
        alu_dataB  = '0;
        alu_signal = '0;
        alu_reset  = 1'b1;
        accept     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // The reset term keeps req_ready low while rst_n is held,
                // even though the registered state already reads IDLE.
                if (rst_n && (|req_valid)) begin
                    req_ready  = arb_gnt;
                    accept     = 1'b1;
                    state_next = sel_supported ? ST_EXEC : ST_RESP;
                end
            end
            ST_EXEC: begin
                alu_dataA  = a_reg;
                alu_dataB  = b_reg;
                alu_signal = funct_reg;
                alu_reset  = 1'b0;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = NREQ'(1) << grant_reg;
                if (rsp_ready[grant_reg]) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            funct_reg  <= '0;
            grant_reg  <= 1'b0;
            result_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg      <= a_arr[arb_idx];
                b_reg      <= b_arr[arb_idx];
                funct_reg  <= funct_arr[arb_idx];
                grant_reg  <= arb_idx;
                // Unsupported codes skip EXEC, so the zero here is the answer.
                result_reg <= '0;
                err_reg    <= ~sel_supported;
            end else if (state_reg == ST_EXEC) begin
                result_reg <= alu_dataOut;
            end
        end
    end

    assign rsp_data = result_reg;
    assign rsp_err  = err_reg;

endmodule

// File: tb/tb_alu_share_arb.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arb
// Directed bench for alu_share_arb with a behavioural external ALU.
// Expected responses are queued when stimulus is issued; a monitor pops and
// compares on every response handshake.
// -----------------------------------------------------------------------------
module tb_alu_share_arb;
    import alu_share_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [11:0] req_funct;
    logic [31:0] alu_dataA;
    logic [31:0] alu_dataB;
    logic [5:0]  alu_signal;
    logic        alu_reset;
    logic [31:0] alu_dataOut;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [1:0]  rsp_ready;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic [1:0] mon_oh;

    always #5 clk = ~clk;

    alu_share_arb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_funct   (req_funct),
        .alu_dataA   (alu_dataA),
        .alu_dataB   (alu_dataB),
        .alu_signal  (alu_signal),
        .alu_reset   (alu_reset),
        .alu_dataOut (alu_dataOut),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .rsp_ready   (rsp_ready)
    );

    // External shared ALU
    always_comb begin
        alu_dataOut = 32'd0;
        if (!alu_reset) begin
            case (alu_signal)
                F_AND:   alu_dataOut = alu_dataA & alu_dataB;
                F_OR:    alu_dataOut = alu_dataA | alu_dataB;
                F_ADD:   alu_dataOut = alu_dataA + alu_dataB;
                F_SUB:   alu_dataOut = alu_dataA - alu_dataB;
                F_SLT:   alu_dataOut = {31'd0, ($signed(alu_dataA) < $signed(alu_dataB))};
                default: alu_dataOut = 32'd0;
            endcase
        end
    end

    // Response monitor
    always @(negedge clk) begin
        if (rst_n && ((rsp_valid & rsp_ready) != 2'b00)) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected: got valid=%b data=%h err=%b, required no response",
                         rsp_valid, rsp_data, rsp_err);
            end else begin
                mon_e  = sb.pop_front();
                mon_oh = 2'b01 << mon_e.idx;
                if (rsp_valid != mon_oh || rsp_data != mon_e.data || rsp_err != mon_e.err) begin
                    failures++;
                    $display("FAIL rsp_match: got valid=%b data=%h err=%b, required valid=%b data=%h err=%b",
                             rsp_valid, rsp_data, rsp_err, mon_oh, mon_e.data, mon_e.err);
                end else begin
                    $display("rsp req%0d data=%h err=%b ok", mon_e.idx, rsp_data, rsp_err);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input logic [31:0] data, input logic err);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    // Check the grant seen in this IDLE cycle, then let the transfer happen.
    task automatic accept(input logic [1:0] exp, input string name);
        @(negedge clk);
        chk(name, {30'd0, req_ready}, {30'd0, exp});
        tick();
    endtask

    // Wait (bounded) for a response handshake, then step past it.
    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((rsp_valid & rsp_ready) != 2'b00) begin
                done = 1'b1;
                break;
            end
        end
        tick();
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s: no response handshake within 20 cycles, required one", name);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_a     = 64'd0;
        req_b     = 64'd0;
        req_funct = {F_ADD, F_ADD};
        rsp_ready = 2'b11;

        // Reset state (requests present must not be acknowledged)
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_alu_reset", {31'd0, alu_reset}, 32'd1);
        chk("rst_alu_dataA", alu_dataA, 32'd0);
        chk("rst_alu_signal", {26'd0, alu_signal}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        tick();
        req_valid = 2'b00;
        rst_n     = 1'b1;
        tick();

        // Single ADD from req0, cycle-exact latency
        req_a     = {32'd0, 32'd5};
        req_b     = {32'd0, 32'd7};
        req_funct = {6'd0, F_ADD};
        req_valid = 2'b01;
        push(0, 32'd12, 1'b0);
        @(negedge clk);
        chk("add_req_ready_N", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("add_alu_signal_N1", {26'd0, alu_signal}, {26'd0, F_ADD});
        chk("add_alu_reset_N1", {31'd0, alu_reset}, 32'd0);
        chk("add_alu_dataA_N1", alu_dataA, 32'd5);
        chk("add_alu_dataB_N1", alu_dataB, 32'd7);
        chk("add_req_ready_exec", {30'd0, req_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("add_rsp_valid_N2", {30'd0, rsp_valid}, 32'd1);
        tick();
        @(negedge clk);
        chk("add_rsp_valid_after", {30'd0, rsp_valid}, 32'd0);
        tick();

        // SLT from req1 (pointer returns to 0 afterwards)
        req_a     = {32'hFFFF_FFFF, 32'd0};
        req_b     = {32'd1, 32'd0};
        req_funct = {F_SLT, 6'd0};
        req_valid = 2'b10;
        push(1, 32'd1, 1'b0);
        accept(2'b10, "slt_neg_grant");
        req_valid = 2'b00;
        drain("slt_neg_drain");
        req_a     = {32'd1, 32'd0};
        req_b     = {32'hFFFF_FFFF, 32'd0};
        req_valid = 2'b10;
        push(1, 32'd0, 1'b0);
        accept(2'b10, "slt_pos_grant");
        req_valid = 2'b00;
        drain("slt_pos_drain");

        // Simultaneous requests alternate
        req_a     = {32'h0000_00F0, 32'd10};
        req_b     = {32'h0000_000F, 32'd3};
        req_funct = {F_OR, F_SUB};
        req_valid = 2'b11;
        push(0, 32'd7, 1'b0);
        accept(2'b01, "pair1_grant");
        req_a[31:0]     = 32'd2;
        req_b[31:0]     = 32'd3;
        req_funct[5:0]  = F_ADD;
        push(1, 32'h0000_00FF, 1'b0);
        drain("pair1_drain");
        accept(2'b10, "pair2_grant");
        req_a[63:32]    = 32'h0000_00F0;
        req_b[63:32]    = 32'h0000_00FF;
        req_funct[11:6] = F_AND;
        push(0, 32'd5, 1'b0);
        drain("pair2_drain");
        accept(2'b01, "pair3_grant");
        req_valid = 2'b10;
        push(1, 32'h0000_00F0, 1'b0);
        drain("pair3_drain");
        accept(2'b10, "solo_req1_grant");
        req_valid = 2'b00;
        drain("solo_req1_drain");

        // Unsupported funct: error response one cycle after acceptance
        req_a     = {32'd0, 32'd9};
        req_b     = {32'd0, 32'd9};
        req_funct = 12'd0;
        req_valid = 2'b01;
        push(0, 32'd0, 1'b1);
        @(negedge clk);
        chk("bad_req_ready_N", {30'd0, req_ready}, 32'd1);
        chk("bad_alu_reset_N", {31'd0, alu_reset}, 32'd1);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("bad_rsp_valid_N1", {30'd0, rsp_valid}, 32'd1);
        chk("bad_rsp_err_N1", {31'd0, rsp_err}, 32'd1);
        chk("bad_alu_reset_N1", {31'd0, alu_reset}, 32'd1);
        tick();
        @(negedge clk);
        chk("bad_rsp_valid_after", {30'd0, rsp_valid}, 32'd0);
        tick();

        // Response back-pressure; the other requester's ready is ignored
        rsp_ready = 2'b10;
        req_a     = {32'd0, 32'h10};
        req_b     = {32'd0, 32'h20};
        req_funct = {6'd0, F_ADD};
        req_valid = 2'b01;
        push(0, 32'h30, 1'b0);
        accept(2'b01, "bp_grant");
        req_a[31:0]    = 32'd9;
        req_b[31:0]    = 32'd4;
        req_funct[5:0] = F_SUB;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid_hold", {30'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_data_hold", rsp_data, 32'h30);
            chk("bp_req_ready_low", {30'd0, req_ready}, 32'd0);
            tick();
        end
        rsp_ready = 2'b11;
        push(0, 32'd5, 1'b0);
        @(negedge clk);
        tick();
        accept(2'b01, "bp_reaccept_next");
        req_valid = 2'b00;
        drain("bp_second_drain");

        // Reset during EXEC aborts the operation
        req_a     = {32'd0, 32'd1};
        req_b     = {32'd0, 32'd2};
        req_funct = {6'd0, F_ADD};
        req_valid = 2'b01;
        accept(2'b01, "abort_grant");
        @(negedge clk);
        chk("abort_in_exec", {31'd0, alu_reset}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_alu_reset", {31'd0, alu_reset}, 32'd1);
        chk("abort_alu_dataA", alu_dataA, 32'd0);
        chk("abort_alu_signal", {26'd0, alu_signal}, 32'd0);
        chk("abort_req_ready", {30'd0, req_ready}, 32'd0);
        chk("abort_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        req_valid = 2'b00;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", {30'd0, rsp_valid}, 32'd0);
        end
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
